preproc_deser: RTL and testbench
================================

# preproc_deser

Parametrised serial-to-parallel capture block: the next generation of the single-bit-in / fixed-width-out preprocessor test module. It samples a strobed serial bit stream into WIDTH-bit words and buffers them in a DEPTH-entry first-word-fall-through FIFO. Words leave through a valid/ready handshake. It sits between a serial front end and any word-wide consumer in the same clock domain.

## Interface
- WIDTH, 16, word width in bits (≥2)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- MSB_FIRST, 1, 1: first received bit lands in out[WIDTH-1]; 0: first received bit lands in out[0]
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- x  input  1  serial data bit
- x_en  input  1  bit strobe; x sampled when high
- sync  input  1  frame start; clears the bit counter
- out  output  WIDTH  head-of-FIFO word
- out_valid  output  1  head word valid
- out_ready  input  1  consumer accepts head word
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky; word dropped because FIFO full
- clr_ovf  input  1  clears overflow
- parity_err  output  1  one-cycle pulse on parity failure (tied 0 unless macro defined)

## Operation
- Reset values: out=0, out_valid=0, count=0, overflow=0, parity_err=0, bit counter=0, shift register=0.
- Bit counter runs 0..FRAME-1. FRAME=WIDTH, or WIDTH+1 with the parity macro. Each x_en shifts x in and increments the counter.
- Completion: x_en with counter=FRAME-1. The assembled word (including this bit) is pushed on that edge and the counter wraps to 0.
- sync without x_en: counter→0, partial word discarded.
- sync with x_en: counter→0 first; the current x becomes bit 0 of a new frame, so the counter ends at 1.
- Pop: out_valid && out_ready on an edge. Head advances.
- Push when not full: accepted.
- Push when full and no pop on the same edge: word dropped, overflow←1.
- Push when full with a pop on the same edge: push accepted, count unchanged, no overflow.
- Push and pop on the same edge when not full: count unchanged.
- Push and pop on the same edge when count=1: the new word becomes head next cycle with no out_valid gap.
- clr_ovf clears overflow. A new overflow event on the same edge wins: overflow stays 1.
- Pointers wrap modulo DEPTH. count=DEPTH means full; count=0 means empty.
- out holds its last value when empty. out_valid=(count≠0).
- Asserting rst_n low mid-frame or with a non-empty FIFO immediately returns all state to reset values.

## Timing
- Push latency: out_valid rises the cycle after the completing edge when the FIFO was empty. out is valid in the same cycle.
- out, out_valid and count are registered outputs. There is no combinational path from x, x_en or sync to any output.
- out_ready may combinationally depend on out_valid. The block never depends combinationally on out_ready.
- Full throughput: one word per FRAME strobes. x_en may be high every cycle.

## Configuration
- Macro: PREPROC_DESER_PARITY_EN.
- Defined:
  - FRAME=WIDTH+1; the final bit is even parity over the WIDTH data bits.
  - On completion with correct parity: word pushed as normal.
  - On completion with wrong parity: word discarded (no push, no overflow), parity_err high for exactly one cycle after the completing edge.
- Undefined: FRAME=WIDTH, no parity bit, parity_err constant 0.

## Test plan
1. Assert rst_n low with random inputs, then release → out=0, out_valid=0, count=0, overflow=0.
2. WIDTH=8, MSB_FIRST=1: shift 0xA5 MSB first with x_en every cycle, out_ready=0 → out_valid=1 the cycle after the 8th bit, out=0xA5, count=1. With MSB_FIRST=0, the same bit sequence yields out=0xA5 bit-reversed (0xA5).
3. DEPTH=4: push 0x11, 0x22, 0x33, 0x44, 0x55 with no pops → count=4, overflow=1. Popping then yields 0x11, 0x22, 0x33, 0x44, then out_valid=0.
4. After 3 bits, pulse sync without x_en, then send 0x3C → only 0x3C pushed, count=1. Repeat with sync coincident with x_en → the new frame includes that bit.
5. FIFO full, out_ready=1 on the same edge as a completion of 0x77 → count stays 4, overflow stays 0, 0x77 popped last. clr_ovf coincident with an overflow event → overflow=1.
6. PARITY_EN: send 0xA5 followed by parity 0 → accepted, count=1. Send 0xA5 followed by parity 1 → not pushed, parity_err=1 for one cycle, count unchanged.

Source files
------------

// File: rtl/preproc_deser.sv
// Strobed serial-to-parallel capture with a first-word-fall-through FIFO.
// Optional parity frame bit enabled by defining PREPROC_DESER_PARITY_EN.
module preproc_deser #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     x,
    input  logic                     x_en,
    input  logic                     sync,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic                     parity_err
);

    localparam int PW = $clog2(DEPTH);
`ifdef PREPROC_DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);

    logic [CW-1:0]    r_bcnt;
    logic [CW-1:0]    w_bcnt_base;
    logic [CW-1:0]    w_bcnt_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_base;
    logic [WIDTH-1:0] w_sr_shift;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic             w_data_bit;
    logic             w_push_req;
    logic             w_par_bad;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    w_rd_nxt;
    logic [PW:0]      r_count;
    logic [PW:0]      w_count_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic             r_valid;
    logic             r_ovf;
    logic             r_perr;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;

    // sync restarts the frame before the current strobe is considered
    always_comb begin
        w_bcnt_base = sync ? '0 : r_bcnt;
        w_sr_base   = sync ? '0 : r_sr;
        if (MSB_FIRST != 0)
            w_sr_shift = {w_sr_base[WIDTH-2:0], x};
        else
            w_sr_shift = {x, w_sr_base[WIDTH-1:1]};
        w_last = x_en && (w_bcnt_base == CW'(FRAME - 1));
`ifdef PREPROC_DESER_PARITY_EN
        w_data_bit = x_en && (w_bcnt_base < CW'(WIDTH));
        w_word     = w_sr_base;
        w_par_bad  = w_last && ((^w_sr_base) ^ x);
        w_push_req = w_last && !w_par_bad;
`else
        w_data_bit = x_en;
        w_word     = w_sr_shift;
        w_par_bad  = 1'b0;
        w_push_req = w_last;
`endif
        w_sr_nxt   = w_data_bit ? w_sr_shift : w_sr_base;
        w_bcnt_nxt = w_bcnt_base;
        if (x_en)
            w_bcnt_nxt = w_last ? '0 : w_bcnt_base + CW'(1);
    end

    always_comb begin
        w_pop    = r_valid && out_ready;
        w_full   = (r_count == (PW+1)'(DEPTH));
        w_push   = w_push_req && (!w_full || w_pop);
        w_drop   = w_push_req && w_full && !w_pop;
        w_rd_nxt = r_rd + PW'(1);
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + (PW+1)'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - (PW+1)'(1);
        // head is the incoming word only when nothing else will be left
        w_out_nxt = r_out;
        if (w_push && (r_count == '0 || (w_pop && r_count == (PW+1)'(1))))
            w_out_nxt = w_word;
        else if (w_pop && r_count > (PW+1)'(1))
            w_out_nxt = r_mem[w_rd_nxt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
            r_sr   <= '0;
        end else begin
            r_bcnt <= w_bcnt_nxt;
            r_sr   <= w_sr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_word;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop)
                r_rd <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_out   <= w_out_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
            r_perr <= w_par_bad;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign count     = r_count;
    assign overflow  = r_ovf;
`ifdef PREPROC_DESER_PARITY_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_preproc_deser.sv
// Self-checking bench for preproc_deser: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_preproc_deser;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int CNTW = $clog2(D) + 1;
`ifdef PREPROC_DESER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            x, x_en, sync, out_ready, clr_ovf;
    logic [W-1:0]    out_m, out_l;
    logic            val_m, val_l;
    logic [CNTW-1:0] cnt_m, cnt_l;
    logic            ovf_m, ovf_l;
    logic            perr_m, perr_l;

    int checks   = 0;
    int failures = 0;

    bit           pbits[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last;
    bit           m_ovf;
    bit           m_perr;

    always #5 clk = ~clk;

    preproc_deser #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .x(x), .x_en(x_en), .sync(sync),
        .out(out_m), .out_valid(val_m), .out_ready(out_ready),
        .count(cnt_m), .overflow(ovf_m), .clr_ovf(clr_ovf),
        .parity_err(perr_m)
    );

    preproc_deser #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .x(x), .x_en(x_en), .sync(sync),
        .out(out_l), .out_valid(val_l), .out_ready(out_ready),
        .count(cnt_l), .overflow(ovf_l), .clr_ovf(clr_ovf),
        .parity_err(perr_l)
    );

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++)
            r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pbits.delete();
        mq.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
    endtask

    // Reference behaviour for one rising edge, from the current inputs
    task automatic model_edge();
        bit           pop;
        bit           preq;
        bit           pok;
        bit           ovf_ev;
        int           sz0;
        int           ones;
        logic [W-1:0] w;
        pop    = (mq.size() != 0) && out_ready;
        sz0    = mq.size();
        preq   = 1'b0;
        pok    = 1'b1;
        ovf_ev = 1'b0;
        w      = '0;
        if (sync) pbits.delete();
        if (x_en) pbits.push_back(x);
        if (pbits.size() == FRAME) begin
            preq = 1'b1;
            ones = 0;
            for (int i = 0; i < W; i++)
                w = {w[W-2:0], pbits[i]};
            for (int i = 0; i < FRAME; i++)
                ones += int'(pbits[i]);
`ifdef PREPROC_DESER_PARITY_EN
            pok = (ones % 2) == 0;
`endif
            pbits.delete();
        end
        if (pop) void'(mq.pop_front());
        if (preq && pok) begin
            if (sz0 < D || pop) mq.push_back(w);
            else ovf_ev = 1'b1;
        end
        m_perr = preq && !pok;
        if (clr_ovf) m_ovf = 1'b0;
        if (ovf_ev) m_ovf = 1'b1;
        if (mq.size() != 0) m_last = mq[0];
    endtask

    task automatic check_all();
        chk("valid", 32'(val_m), 32'(mq.size() != 0));
        chk("count", 32'(cnt_m), 32'(mq.size()));
        chk("ovf", 32'(ovf_m), 32'(m_ovf));
        chk("perr", 32'(perr_m), 32'(m_perr));
        chk("out_msb", 32'(out_m), 32'(m_last));
        chk("out_lsb", 32'(out_l), 32'(rev(m_last)));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        x = 0; x_en = 0; sync = 0; out_ready = 0; clr_ovf = 0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit flip,
                             input bit sync_first, input bit rdy_last,
                             input bit clr_last);
        logic [W-1:0] wv;
        wv = w;
        for (int i = 0; i < FRAME; i++) begin
            x_en      = 1'b1;
            x         = (i < W) ? wv[W-1-i] : ((^wv) ^ flip);
            sync      = sync_first && (i == 0);
            out_ready = rdy_last && (i == FRAME - 1);
            clr_ovf   = clr_last && (i == FRAME - 1);
            tick();
        end
        idle();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < D + 1; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] seq [5];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        seq[3] = 8'h44; seq[4] = 8'h55;
        idle();
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            {x, x_en, sync, out_ready, clr_ovf} = 5'($urandom);
        end
        chk("rst_out", 32'(out_m), 0);
        chk("rst_valid", 32'(val_m), 0);
        chk("rst_count", 32'(cnt_m), 0);
        chk("rst_ovf", 32'(ovf_m), 0);
        idle();
        #2 rst_n = 1'b1;
        tick();

        send_word(8'hA5, 0, 0, 0, 0);
        chk("a5_count", 32'(cnt_m), 1);
        chk("a5_out", 32'(out_m), 32'h A5);
        chk("a5_lsb", 32'(out_l), 32'h A5);
        drain();

        for (int k = 0; k < 5; k++) send_word(seq[k], 0, 0, 0, 0);
        chk("full_count", 32'(cnt_m), 4);
        chk("full_ovf", 32'(ovf_m), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("pop_order", 32'(out_m), 32'(seq[k]));
            tick();
        end
        chk("pop_empty", 32'(val_m), 0);
        idle();

        x_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 1'($urandom);
            tick();
        end
        x_en = 1'b0; sync = 1'b1;
        tick();
        sync = 1'b0;
        send_word(8'h3C, 0, 0, 0, 0);
        chk("sync_count", 32'(cnt_m), 1);
        chk("sync_out", 32'(out_m), 32'h3C);
        drain();
        x_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 1'($urandom);
            tick();
        end
        send_word(8'h3C, 0, 1, 0, 0);
        chk("sync_en_count", 32'(cnt_m), 1);
        chk("sync_en_out", 32'(out_m), 32'h3C);
        drain();

        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf_m), 0);
        for (int k = 0; k < 4; k++) send_word(W'($urandom), 0, 0, 0, 0);
        send_word(8'h77, 0, 0, 1, 0);
        chk("pp_count", 32'(cnt_m), 4);
        chk("pp_ovf", 32'(ovf_m), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("pp_last", 32'(out_m), 32'h77);
        drain();
        for (int k = 0; k < 4; k++) send_word(W'($urandom), 0, 0, 0, 0);
        send_word(8'h99, 0, 0, 0, 1);
        chk("clr_vs_ovf", 32'(ovf_m), 1);
        drain();

`ifdef PREPROC_DESER_PARITY_EN
        send_word(8'hA5, 0, 0, 0, 0);
        chk("par_ok_count", 32'(cnt_m), 1);
        send_word(8'hA5, 1, 0, 0, 0);
        chk("par_bad_count", 32'(cnt_m), 1);
        drain();
`endif

        for (int i = 0; i < 600; i++) begin
            x         = 1'($urandom);
            x_en      = $urandom_range(0, 3) != 0;
            sync      = $urandom_range(0, 40) == 0;
            out_ready = $urandom_range(0, 2) == 0;
            clr_ovf   = $urandom_range(0, 30) == 0;
            tick();
        end
        idle();

        send_word(8'hC3, 0, 0, 0, 0);
        x_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 1'b1;
            tick();
        end
        idle();
        rst_n = 1'b0;
        #2;
        chk("arst_out", 32'(out_m), 0);
        chk("arst_valid", 32'(val_m), 0);
        chk("arst_count", 32'(cnt_m), 0);
        chk("arst_ovf", 32'(ovf_m), 0);
        chk("arst_perr", 32'(perr_m), 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        send_word(8'h5A, 0, 0, 0, 0);
        chk("arst_frame", 32'(out_m), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
